// File: rtl/pfq_pkg.sv
// rtl/pfq_pkg.sv - shared types and defaults for the instruction prefetch queue
package pfq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } pfq_state_t;

  localparam int PFQ_DEPTH = 4;
  localparam int PFQ_AW    = 8;

  function automatic int pfq_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int PFQ_PTR_W = pfq_ptr_w(PFQ_DEPTH);

endpackage

// File: rtl/pfq_fifo.sv
// rtl/pfq_fifo.sv - power-of-two circular byte buffer with push, pop and clear
module pfq_fifo
  import pfq_pkg::*;
#(
  parameter int DEPTH = PFQ_DEPTH,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = pfq_ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Empty reads return zero so stale storage never leaks to decode.
  assign rdata = (count != '0) ? mem[head] : '0;

endmodule

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - single-outstanding instruction fetch FSM feeding pfq_fifo
// Optional PFQ_BYPASS_EN forwards an ack straight to decode when the queue is empty.
module instr_prefetch_queue
  import pfq_pkg::*;
#(
  parameter int DEPTH = PFQ_DEPTH,
  parameter int AW    = PFQ_AW
) (
  input  logic                   eclk,
  input  logic                   reset,
  input  logic                   fetch_en,
  input  logic                   flush,
  input  logic [AW-1:0]          flush_addr,
  output logic                   mem_req,
  output logic [AW-1:0]          mem_addr,
  input  logic                   mem_ack,
  input  logic [7:0]             mem_rdata,
  output logic                   ins_valid,
  output logic [7:0]             ins_data,
  input  logic                   ins_pop,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  pfq_state_t    state;
  pfq_state_t    state_next;
  logic [AW-1:0] fa;
  logic          start;
  logic          ack_take;
  logic          push;
  logic          pop;
  logic          full;
  logic [7:0]    head_data;

  assign full    = (count == CW'(DEPTH));
  assign mem_req = (state != IDLE);

  always_ff @(posedge eclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    ack_take   = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_en && !flush && !full) begin
          start      = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          ack_take   = !flush;
          state_next = IDLE;
        end else if (flush) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // mem_addr is latched at request start so a flush during DRAIN leaves it untouched.
  always_ff @(posedge eclk or posedge reset) begin
    if (reset) begin
      fa       <= '0;
      mem_addr <= '0;
    end else begin
      if (flush)         fa <= flush_addr;
      else if (ack_take) fa <= fa + AW'(1);
      if (start) mem_addr <= fa;
    end
  end

`ifdef PFQ_BYPASS_EN
  logic bypass;
  assign bypass    = ack_take && (count == '0);
  assign ins_valid = (count != '0) || bypass;
  assign ins_data  = (count != '0) ? head_data : (bypass ? mem_rdata : 8'h00);
  assign push      = ack_take && !(bypass && ins_pop);
`else
  assign ins_valid = (count != '0);
  assign ins_data  = head_data;
  assign push      = ack_take;
`endif

  assign pop = ins_pop && (count != '0);

  pfq_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (eclk),
    .rst   (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata (mem_rdata),
    .rdata (head_data),
    .count (count)
  );

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving queue entries (power of two, 2..8).
REQ-002 The block SHALL have parameter AW, default 8, giving fetch address width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-004 eclk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 fetch_en  input  1  permits new memory requests.
REQ-007 flush  input  1  branch redirect; discard the queue.
REQ-008 flush_addr  input  AW  new fetch address, sampled with flush.
REQ-009 mem_req  output  1  memory read request.
REQ-010 mem_addr  output  AW  read address, valid while mem_req=1.
REQ-011 mem_ack  input  1  read complete; mem_rdata valid this cycle.
REQ-012 mem_rdata  input  8  instruction byte from memory.
REQ-013 ins_valid  output  1  head entry available to decode.
REQ-014 ins_data  output  8  head instruction byte.
REQ-015 ins_pop  input  1  decode consumes the head; ignored when ins_valid=0.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 States SHALL be IDLE, FETCH and DRAIN; at most one request SHALL be outstanding.
REQ-018 IDLE->FETCH when fetch_en=1, flush=0 and count<DEPTH; mem_req=1 and mem_addr=fa in FETCH.
REQ-019 mem_req and mem_addr SHALL hold stable in FETCH/DRAIN until mem_ack; a request is never withdrawn.
REQ-020 FETCH with mem_ack, no flush: write mem_rdata at tail, fa<=fa+1 (mod 2^AW, 0xFF wraps to 0x00), and return to IDLE.
REQ-021 A request SHALL start only when count<DEPTH; because the queue cannot grow while waiting, an ack never overflows.
REQ-022 Pop (ins_valid & ins_pop) advances the head; push and pop in the same cycle SHALL leave count unchanged and keep FIFO order.
REQ-023 ins_valid=(count!=0); ins_data=head entry; latency from mem_ack to ins_valid is 1 cycle.
REQ-024 flush SHALL take priority over push and pop: count<=0, head/tail<=0, fa<=flush_addr.
REQ-025 flush in FETCH without mem_ack: go to DRAIN, keeping the old mem_addr; when the ack arrives, discard the data, go to IDLE, and leave fa at flush_addr.
REQ-026 flush in the same cycle as mem_ack: discard the data and go to IDLE; flush in DRAIN: update fa only.
REQ-027 fetch_en=0 SHALL block only new requests; an outstanding request still completes normally.

Reset
REQ-028 Reset SHALL force state=IDLE, mem_req=0, mem_addr=0, fa=0, count=0, ins_valid=0, ins_data=0 and pointers=0, immediately and asynchronously, including mid-request.
REQ-029 mem_ack arriving while reset is high SHALL be ignored.

Configuration
REQ-030 With PFQ_BYPASS_EN defined, an ack into an empty queue with no flush SHALL also drive ins_valid=1 and ins_data=mem_rdata combinationally in that cycle. If ins_pop is also high in that cycle, the byte SHALL be consumed and not stored.
REQ-031 Without PFQ_BYPASS_EN, ins_valid/ins_data SHALL depend only on registered queue state, per REQ-023.

Structure
REQ-032 A shared package pfq_pkg SHALL hold the state enum (IDLE/FETCH/DRAIN), the DEPTH/AW defaults and the pointer-width constant.
REQ-033 Storage SHALL be the sub-module pfq_fifo (circular buffer with push/pop/clear); the FSM and fa SHALL reside in the top module.

Verification
REQ-034 Scenario: reset, then fetch_en=1, with memory bytes 0x16,0x16,0x1A,0x04 at addresses 0..3 and ack 1 cycle after req, no pop. Required: mem_addr goes 0,1,2,3; count reaches 4; mem_req stays 0 after that; ins_data=0x16.
REQ-035 Scenario: full queue, pop held high for 4 cycles. Required: ins_data sequence 0x16,0x16,0x1A,0x04; the refill request at address 4 starts once count=3.
REQ-036 Scenario: flush with flush_addr=0x0D while a request to address 2 waits 3 cycles for ack. Required: mem_addr holds 2 until ack; that data is discarded; the next request goes to 0x0D; count=0 until it completes.
REQ-037 Scenario: fa=0xFF, ack. Required: next mem_addr=0x00.
REQ-038 Scenario: assert reset while mem_req=1. Required: mem_req=0 and count=0 immediately; a late mem_ack has no effect.
REQ-039 Scenario (PFQ_BYPASS_EN): empty queue, ack of 0x0F with ins_pop=1 in the same cycle. Required: ins_data=0x0F and ins_valid=1 that cycle; count stays 0.
